// File: rtl/sync_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared definitions for the clock-domain-crossing synchronisers.
//   SYNC_MIN_STAGES : smallest legal synchroniser depth
//   SYNC_MAX_HOLD   : largest legal stability hold count
//   sync_state_t    : IDLE / SETTLE view of the stability qualifier
//   sync_cnt_width  : bit width of a counter that must reach 'hold'
// -----------------------------------------------------------------------------
package sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;
    localparam int SYNC_MAX_HOLD   = 255;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } sync_state_t;

    // Width of a stability counter able to hold values 0..hold.
    function automatic int sync_cnt_width(input int hold);
        if (hold < 1) begin
            return 1;
        end else begin
            return $clog2(hold + 1);
        end
    endfunction

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Bare WIDTH-bit flip-flop synchroniser chain, STAGES deep, synchronous reset.
// No qualification is done here; callers that cross multi-bit data must add
// their own stability or Gray-code handling.
// Ports:
//   wclk  in  1      destination clock
//   reset in  1      synchronous, active-high; clears every stage
//   d     in  WIDTH  asynchronous input
//   q     out WIDTH  output of the last stage
// -----------------------------------------------------------------------------
module sync_chain
    import sync_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             wclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_chain: STAGES must be at least %0d", SYNC_MIN_STAGES);
    end

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge wclk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/sync_bus_stable.sv
// -----------------------------------------------------------------------------
// sync_bus_stable
// Multi-bit CDC receiver for slowly changing, non-Gray buses. Every bit goes
// through sync_chain; a new word is accepted only after the synchronised
// value has held constant for HOLD consecutive cycles, so skewed multi-bit
// transitions never reach data_out. Latency from first capture is
// STAGES+HOLD edges.
// Optional feature macro: SYNC_BUS_STABLE_EDGE_EN adds registered rise/fall
// per-bit edge outputs, valid on the update cycle only.
// Ports:
//   wclk     in  1      destination clock
//   reset    in  1      synchronous, active-high
//   data_in  in  WIDTH  asynchronous source bus
//   data_out out WIDTH  accepted word (registered)
//   update   out 1      one-cycle pulse with each data_out change (registered)
//   settling out 1      high while a new word is being qualified (combinational)
//   rise     out WIDTH  bits going 0->1 on update (edge feature only)
//   fall     out WIDTH  bits going 1->0 on update (edge feature only)
// -----------------------------------------------------------------------------
module sync_bus_stable
    import sync_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int HOLD   = 3
) (
    input  logic             wclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             update,
    output logic             settling
`ifdef SYNC_BUS_STABLE_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`else
    // Edge outputs are not present in this build.
`endif
);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_bus_stable: WIDTH must be at least 1");
    end
    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_bus_stable: STAGES must be at least %0d", SYNC_MIN_STAGES);
    end
    if ((HOLD < 1) || (HOLD > SYNC_MAX_HOLD)) begin : g_bad_hold
        $error("sync_bus_stable: HOLD must be in 1..%0d", SYNC_MAX_HOLD);
    end

    localparam int CNT_W = sync_cnt_width(HOLD);
    // Count value on which the candidate has been stable for HOLD edges.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] cand_r;
    logic [CNT_W-1:0] cnt_r;
    sync_state_t      state_s;

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_chain (
        .wclk  (wclk),
        .reset (reset),
        .d     (data_in),
        .q     (sync_s)
    );

    // Qualifier view: settling whenever the sync output or candidate disagree
    // with what has already been accepted.
    always_comb begin
        state_s = IDLE;
        if ((cand_r != data_out) || (sync_s != cand_r)) begin
            state_s = SETTLE;
        end else begin
            state_s = IDLE;
        end
    end

    assign settling = (state_s == SETTLE);

    // Candidate tracking, stability counting and word acceptance.
    always_ff @(posedge wclk) begin
        if (reset) begin
            cand_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            data_out <= {WIDTH{1'b0}};
            update   <= 1'b0;
`ifdef SYNC_BUS_STABLE_EDGE_EN
            rise     <= {WIDTH{1'b0}};
            fall     <= {WIDTH{1'b0}};
`endif
        end else begin
            update <= 1'b0;
`ifdef SYNC_BUS_STABLE_EDGE_EN
            rise   <= {WIDTH{1'b0}};
            fall   <= {WIDTH{1'b0}};
`endif
            if (sync_s != cand_r) begin
                // Any bit change restarts qualification with the new word.
                cand_r <= sync_s;
                cnt_r  <= {CNT_W{1'b0}};
            end else if (cand_r != data_out) begin
                if (cnt_r == CNT_LAST) begin
                    data_out <= cand_r;
                    update   <= 1'b1;
                    cnt_r    <= {CNT_W{1'b0}};
`ifdef SYNC_BUS_STABLE_EDGE_EN
                    rise     <= cand_r & ~data_out;
                    fall     <= ~cand_r & data_out;
`endif
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: doc/sync_bus_stable.md
# sync_bus_stable

Multi-bit clock-domain-crossing receiver for slowly changing, non-Gray-coded buses such as mode or configuration words written from another domain. Each bit passes through a parametrised flip-flop synchroniser chain into the `wclk` domain. A stability qualifier then accepts a new word only after the synchronised value has held constant for `HOLD` consecutive cycles, so skewed multi-bit transitions never reach `data_out`. It sits at every graphics-core boundary where a CPU-side register feeds pixel-clock logic.

## Interface
- `WIDTH`, 8: bus width in bits, ≥1.
- `STAGES`, 2: synchroniser depth, ≥2.
- `HOLD`, 3: consecutive stable cycles required before acceptance, 1..255.
- `wclk`  in  1  destination clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clock `wclk`.
- `data_in`  in  WIDTH  asynchronous source bus.
- `data_out`  out  WIDTH  accepted word, registered.
- `update`  out  1  one-cycle pulse coincident with each `data_out` change.
- `settling`  out  1  combinational; high while a candidate differs from `data_out` or the sync output differs from the candidate.
- `rise`, `fall`  out  WIDTH each  only with `SYNC_BUS_STABLE_EDGE_EN`; see Configuration.

## Operation
- `s` is the output of the last synchroniser stage. `cand` is the candidate register. `cnt` is the stability counter, `$clog2(HOLD+1)` bits.
- Evaluate these rules in priority order on every edge when `reset` is low:
  - `s != cand`: `cand <= s`, `cnt <= 0`. The new candidate restarts qualification.
  - `s == cand` and `cand != data_out`, with `cnt == HOLD-1`: `data_out <= cand`, `update <= 1`, `cnt <= 0`.
  - `s == cand` and `cand != data_out`, otherwise: `cnt <= cnt+1`.
  - `s == cand == data_out`: `cnt <= 0`. The block is idle.
- `update` is 0 on every edge not covered by the acceptance rule.
- Implied states:
  - IDLE: `cand == data_out`, `s == cand`.
  - SETTLE: counting.
  - If the bus returns to the `data_out` value mid-settle, the block goes back to IDLE with no update.
- The candidate is compared on the whole word. A change in any bit restarts the count.
- Reset clears every synchroniser stage, `cand`, `cnt`, `data_out`, `update`, `rise` and `fall` to 0. `settling` therefore reads 0 after reset.
- Reset asserted mid-settle abandons the candidate. No `update` is produced for it.
- If `data_in` is still nonzero after reset, it is re-synchronised and qualified from scratch.

## Timing
- `data_in` is stable before edge 0 and first captured at edge 0.
- `s` is valid after edge `STAGES-1`.
- `cand` loads at edge `STAGES`.
- `data_out` and `update` change at edge `STAGES+HOLD`.
- Total latency is `STAGES+HOLD` cycles: 5 with the defaults.
- A change seen on `s` for fewer than `HOLD+1` cycles never reaches `data_out`.
- Back-to-back accepted words are at least `HOLD+1` cycles apart.
- `update` is never high on two consecutive cycles.

## Configuration
- `SYNC_BUS_STABLE_EDGE_EN` defined:
  - Ports `rise` and `fall` exist and are registered.
  - On the same edge as `update`, `rise <= cand & ~data_out` and `fall <= ~cand & data_out`.
  - At every other edge both are 0.
- Not defined: the ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `sync_pkg` holds:
  - the `SYNC_MIN_STAGES = 2` constant;
  - the count-width function `sync_cnt_width(hold)`;
  - the `sync_state_t` enum (IDLE, SETTLE) for waveform and assertion use.
- One sub-module, `sync_chain`, parametrised by `WIDTH` and `STAGES`: a bare flop chain with synchronous reset. `sync_bus_stable` instantiates it once. Other single-bit or Gray-coded crossings reuse it directly.
- Parameter checks (`STAGES ≥ 2`, `1 ≤ HOLD ≤ 255`) are elaboration-time errors.

## Test plan
- Reset with `data_in=0x00` for 10 cycles → `data_out=0x00`, `update=0`, `settling=0` throughout.
- Defaults; `data_in` 0x00→0xA5 held → `data_out=0xA5` and a single `update` pulse exactly 5 edges after first capture.
- `data_in` 0x00→0xA5 for 2 cycles, then back to 0x00 → no `update`; `data_out` stays 0x00; `settling` returns to 0.
- Bouncing 0x0F/0x1F/0x0F every cycle for 6 cycles, then 0x1F held → exactly one `update`, to 0x1F, `STAGES+HOLD` edges after the final change.
- `reset` pulsed at SETTLE cycle 2 with 0x3C pending and held on input → no `update` before reset; after reset, `update` to 0x3C exactly 5 edges after release.
- `SYNC_BUS_STABLE_EDGE_EN`, 0x0F→0xF0 accepted → `rise=0xF0`, `fall=0x0F` on the `update` cycle and 0 on the next.
